// File: rtl/pwm_distance_pkg.sv
// Shared helpers for the multi-channel distance-to-PWM controller:
// counter width, slew-limited step and distance-to-duty mapping.
package pwm_distance_pkg;

  function automatic int unsigned cnt_width(
    input int unsigned period
  );
    return $clog2(period + 1);
  endfunction

  function automatic logic [31:0] sat_step(
    input logic [31:0] cur,
    input logic [31:0] tgt,
    input logic [31:0] step
  );
    logic [31:0] diff;
    if (step == 32'd0) return tgt;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > step) ? cur + step : tgt;
    end
    diff = cur - tgt;
    return (diff > step) ? cur - step : tgt;
  endfunction

  function automatic logic [31:0] dist_to_duty(
    input logic [63:0] d,
    input logic [63:0] near,
    input logic [63:0] far,
    input int unsigned shift,
    input logic [31:0] period
  );
    logic [63:0] q;
    if (d <= near) return period;
    if (d >= far) return 32'd0;
    q = (far - d) >> shift;
    if (q > {32'd0, period}) return period;
    return q[31:0];
  endfunction

endpackage

// File: rtl/pwm_distance_channel.sv
// One channel: target mapping, slew-limited duty, stale timeout
// and the registered PWM comparator against the shared counter.
module pwm_distance_channel
  import pwm_distance_pkg::*;
#(
  parameter int unsigned DIST_W          = 32,
  parameter int unsigned PERIOD          = 100,
  parameter int unsigned D_NEAR          = 200000,
  parameter int unsigned D_FAR           = 2000000,
  parameter int unsigned SHIFT           = 14,
  parameter int unsigned STEP            = 10,
  parameter int unsigned TIMEOUT_PERIODS = 8,
  parameter int unsigned CNT_W           = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              wrap_i,
  input  logic [DIST_W-1:0] distance_i,
  input  logic              valid_i,
  output logic              pwm_o,
  output logic [CNT_W-1:0]  duty_o,
  output logic              stale_o
);

  localparam int unsigned AGE_W = $clog2(TIMEOUT_PERIODS + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_PERIODS);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             stale_q, stale_d;
  logic             pwm_q, pwm_d;
  logic [31:0]      map_w;
  logic [31:0]      step_w;

  // Mapped duty of the incoming sample and the next slewed duty.
  always_comb begin
    map_w  = dist_to_duty(64'(distance_i), 64'(D_NEAR),
                          64'(D_FAR), SHIFT, PERIOD);
    step_w = sat_step(32'(duty_q), 32'(target_q), STEP);
  end

  // Next state: duty moves only at wrap; a fresh sample beats timeout.
  always_comb begin
    target_d = target_q;
    duty_d   = duty_q;
    age_d    = age_q;
    stale_d  = stale_q;
    pwm_d    = (cnt_i < duty_q);
    if (wrap_i) begin
      duty_d = step_w[CNT_W-1:0];
      if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
    end
    if (valid_i) begin
      target_d = map_w[CNT_W-1:0];
      age_d    = '0;
      stale_d  = 1'b0;
    end else if (wrap_i && (age_d == AGE_MAX)) begin
      target_d = '0;
      stale_d  = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      duty_q   <= '0;
      age_q    <= '0;
      stale_q  <= 1'b1;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      age_q    <= age_d;
      stale_q  <= stale_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign duty_o  = duty_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/pwm_distance_multi.sv
// Multi-channel distance-to-PWM controller with one shared
// period counter feeding NUM_CH independent channels.
module pwm_distance_multi
  import pwm_distance_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DIST_W          = 32,
  parameter int unsigned PERIOD          = 100,
  parameter int unsigned D_NEAR          = 200000,
  parameter int unsigned D_FAR           = 2000000,
  parameter int unsigned SHIFT           = 14,
  parameter int unsigned STEP            = 10,
  parameter int unsigned TIMEOUT_PERIODS = 8,
  localparam int unsigned CNT_W          = cnt_width(PERIOD)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0][DIST_W-1:0] distance,
  input  logic [NUM_CH-1:0]            distance_valid,
  output logic [NUM_CH-1:0]            pwm,
  output logic [NUM_CH-1:0][CNT_W-1:0] duty_cycle,
  output logic [NUM_CH-1:0]            stale,
  output logic                         period_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             wrap;

  // Shared period counter; period_start tracks cnt==0.
  always_comb begin
    wrap           = (cnt_q == LAST);
    cnt_d          = wrap ? '0 : cnt_q + CNT_W'(1);
    period_start_d = (cnt_d == '0);
  end

  // Counter and period_start registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_distance_channel #(
      .DIST_W          (DIST_W),
      .PERIOD          (PERIOD),
      .D_NEAR          (D_NEAR),
      .D_FAR           (D_FAR),
      .SHIFT           (SHIFT),
      .STEP            (STEP),
      .TIMEOUT_PERIODS (TIMEOUT_PERIODS),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_i      (cnt_q),
      .wrap_i     (wrap),
      .distance_i (distance[i]),
      .valid_i    (distance_valid[i]),
      .pwm_o      (pwm[i]),
      .duty_o     (duty_cycle[i]),
      .stale_o    (stale[i])
    );
  end

endmodule

// File: tb/tb_pwm_distance_multi.sv
// Bench for pwm_distance_multi: STEP=10 and STEP=0 instances,
// directed table, corner sequences and randomized model check.
module tb_pwm_distance_multi;

  localparam int P    = 100;
  localparam int T    = 8;
  localparam int NEAR = 200000;
  localparam int FAR  = 2000000;
  localparam int SH   = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0][31:0] distance = '0;
  logic [3:0]      valid = '0;
  logic [3:0]      pwm_a, pwm_b;
  logic [3:0][6:0] duty_a, duty_b;
  logic [3:0]      stale_a, stale_b;
  logic            ps_a, ps_b;

  always #5 clk = ~clk;

  pwm_distance_multi #(.STEP(10)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .distance(distance), .distance_valid(valid),
    .pwm(pwm_a), .duty_cycle(duty_a),
    .stale(stale_a), .period_start(ps_a)
  );

  pwm_distance_multi #(.STEP(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .distance(distance), .distance_valid(valid),
    .pwm(pwm_b), .duty_cycle(duty_b),
    .stale(stale_b), .period_start(ps_b)
  );

  int vec = 0;
  int err = 0;
  int cyc = 0;

  int m_cnt;
  bit m_ps;
  int m_tgt[2][4];
  int m_duty[2][4];
  int m_age[2][4];
  bit m_stale[2][4];
  bit m_pwm[2][4];

  typedef struct {
    int         d[4];
    logic [3:0] v;
    int         w;
    int         e10[4];
    int         e0[4];
    logic [3:0] st;
  } row_t;
  row_t rows[4];

  function automatic int stp(int d);
    return (d == 0) ? 10 : 0;
  endfunction

  function automatic int ref_map(longint d);
    longint q;
    if (d <= NEAR) return P;
    if (d >= FAR) return 0;
    q = (FAR - d) / (longint'(1) << SH);
    return (q > P) ? P : int'(q);
  endfunction

  function automatic int ref_slew(int cur, int tgt, int s);
    int delta;
    if (s == 0) return tgt;
    delta = tgt - cur;
    if (delta > s) delta = s;
    if (delta < -s) delta = -s;
    return cur + delta;
  endfunction

  task automatic check(string n, longint got, longint exp);
    vec++;
    if (got != exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ps  = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_tgt[d][c]   = 0;
        m_duty[d][c]  = 0;
        m_age[d][c]   = 0;
        m_stale[d][c] = 1'b1;
        m_pwm[d][c]   = 1'b0;
      end
  endtask

  task automatic model_edge();
    int  c;
    bit  wrap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c = m_cnt;
    wrap = (c == P - 1);
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 4; ch++) begin
        m_pwm[d][ch] = (c < m_duty[d][ch]);
        if (wrap) begin
          m_duty[d][ch] = ref_slew(m_duty[d][ch],
                                   m_tgt[d][ch], stp(d));
          if (m_age[d][ch] < T) m_age[d][ch]++;
        end
        if (valid[ch]) begin
          m_tgt[d][ch]   = ref_map(longint'({32'd0, distance[ch]}));
          m_age[d][ch]   = 0;
          m_stale[d][ch] = 1'b0;
        end else if (wrap && m_age[d][ch] == T) begin
          m_tgt[d][ch]   = 0;
          m_stale[d][ch] = 1'b1;
        end
      end
    m_cnt = wrap ? 0 : c + 1;
    m_ps  = (m_cnt == 0);
  endtask

  task automatic compare_model();
    logic [3:0]  ep, es;
    logic [27:0] ed;
    for (int d = 0; d < 2; d++) begin
      ep = '0;
      es = '0;
      ed = '0;
      for (int c = 0; c < 4; c++) begin
        ep[c] = m_pwm[d][c];
        es[c] = m_stale[d][c];
        ed[c*7 +: 7] = 7'(m_duty[d][c]);
      end
      if (d == 0) begin
        check($sformatf("a pwm cyc%0d", cyc), pwm_a, ep);
        check($sformatf("a stale cyc%0d", cyc), stale_a, es);
        check($sformatf("a duty cyc%0d", cyc), duty_a, ed);
        check($sformatf("a pstart cyc%0d", cyc), ps_a, m_ps);
      end else begin
        check($sformatf("b pwm cyc%0d", cyc), pwm_b, ep);
        check($sformatf("b stale cyc%0d", cyc), stale_b, es);
        check($sformatf("b duty cyc%0d", cyc), duty_b, ed);
        check($sformatf("b pstart cyc%0d", cyc), ps_b, m_ps);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic run_to_cnt(int c);
    int n = 0;
    while (m_cnt != c && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wraps(int n);
    repeat (n) begin
      run_to_cnt(P - 1);
      tick();
    end
  endtask

  task automatic pulse(logic [3:0] v, int d0, int d1,
                       int d2, int d3);
    distance[0] = 32'(d0);
    distance[1] = 32'(d1);
    distance[2] = 32'(d2);
    distance[3] = 32'(d3);
    valid = v;
    tick();
    valid = '0;
  endtask

  task automatic count_period(int ch, output int na,
                              output int nb);
    na = 0;
    nb = 0;
    run_to_cnt(0);
    repeat (P) begin
      tick();
      na += int'(pwm_a[ch]);
      nb += int'(pwm_b[ch]);
    end
  endtask

  task automatic mid_reset_check(int at);
    run_to_cnt(at);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst pwm a", pwm_a, 0);
    check("rst pwm b", pwm_b, 0);
    check("rst duty a", duty_a, 0);
    check("rst duty b", duty_b, 0);
    check("rst stale a", stale_a, 4'hf);
    check("rst stale b", stale_b, 4'hf);
    check("rst pstart a", ps_a, 0);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin : main
    int na, nb, first, gap, seen;
    int rate, r;
    logic [3:0] v;

    rows[0].d = '{200005, 1100002, 1999999, 50};
    rows[0].v = 4'b1111;
    rows[0].w = 1;
    rows[0].e10 = '{10, 10, 0, 10};
    rows[0].e0  = '{100, 54, 0, 100};
    rows[0].st  = 4'b0000;
    rows[1].d = '{0, 0, 0, 0};
    rows[1].v = 4'b0000;
    rows[1].w = 5;
    rows[1].e10 = '{60, 54, 0, 60};
    rows[1].e0  = '{100, 54, 0, 100};
    rows[1].st  = 4'b0000;
    rows[2].d = '{1999999, 0, 0, 0};
    rows[2].v = 4'b0001;
    rows[2].w = 2;
    rows[2].e10 = '{40, 54, 0, 80};
    rows[2].e0  = '{0, 54, 0, 100};
    rows[2].st  = 4'b1110;
    rows[3].d = '{0, 0, 0, 0};
    rows[3].v = 4'b0000;
    rows[3].w = 3;
    rows[3].e10 = '{10, 24, 0, 50};
    rows[3].e0  = '{0, 0, 0, 0};
    rows[3].st  = 4'b1110;

    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("init pwm", pwm_a, 0);
    check("init duty", duty_a, 0);
    check("init stale", stale_a, 4'hf);
    check("init pstart", ps_a, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    first = -1;
    gap = 0;
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (ps_a && seen == 0) begin
        first = cyc;
        seen = 1;
      end else if (ps_a && seen == 1) begin
        gap = cyc - first;
        seen = 2;
      end
    end
    check("pstart gap", gap, P);

    for (int i = 0; i < 4; i++) begin
      run_to_cnt(5);
      if (rows[i].v != 0)
        pulse(rows[i].v, rows[i].d[0], rows[i].d[1],
              rows[i].d[2], rows[i].d[3]);
      wraps(rows[i].w);
      for (int c = 0; c < 4; c++) begin
        check($sformatf("row%0d a duty%0d", i, c),
              duty_a[c], rows[i].e10[c]);
        check($sformatf("row%0d b duty%0d", i, c),
              duty_b[c], rows[i].e0[c]);
      end
      check($sformatf("row%0d a stale", i), stale_a, rows[i].st);
      check($sformatf("row%0d b stale", i), stale_b, rows[i].st);
    end

    run_to_cnt(5);
    pulse(4'b0010, 0, 1100002, 0, 0);
    for (int k = 0; k < 3; k++) begin
      count_period(1, na, nb);
      check($sformatf("ramp a high%0d", k), na, 34 + 10 * k);
      check($sformatf("ramp b high%0d", k), nb, 54);
    end

    run_to_cnt(5);
    pulse(4'b0100, 0, 0, 50, 0);
    wraps(5);
    run_to_cnt(5);
    pulse(4'b0100, 0, 0, 50, 0);
    wraps(5);
    check("to a duty full", duty_a[2], 100);
    count_period(2, na, nb);
    check("to b high full", nb, P);
    wraps(1);
    check("to stale age7", stale_a[2], 0);
    run_to_cnt(P - 1);
    distance[2] = 32'd50;
    valid = 4'b0100;
    tick();
    valid = '0;
    check("to a valid@wrap", stale_a[2], 0);
    check("to b valid@wrap", stale_b[2], 0);
    wraps(7);
    check("to stale w7", stale_a[2], 0);
    wraps(1);
    check("to a stale w8", stale_a[2], 1);
    check("to b stale w8", stale_b[2], 1);
    check("to a duty w8", duty_a[2], 100);
    wraps(1);
    check("to a duty w9", duty_a[2], 90);
    check("to b duty w9", duty_b[2], 0);
    wraps(1);
    check("to a duty w10", duty_a[2], 80);

    run_to_cnt(5);
    pulse(4'b1111, 50, 50, 50, 50);
    wraps(1);
    mid_reset_check(50);

    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1500) ? 40 : 1500;
      v = '0;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, rate - 1) == 0) begin
          v[c] = 1'b1;
          r = int'($urandom_range(0, 4));
          unique case (r)
            0: distance[c] = $urandom_range(0, NEAR);
            1: distance[c] = $urandom_range(FAR, FAR + 100000);
            2: distance[c] = $urandom_range(NEAR + 1, FAR - 1);
            3: distance[c] = ($urandom_range(0, 1) == 0)
                             ? 32'(NEAR + 1) : 32'(FAR - 1);
            default: distance[c] = $urandom;
          endcase
        end
      end
      valid = v;
      tick();
      valid = '0;
      if (i == 1200) mid_reset_check(int'($urandom_range(1, 98)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
